// File: rtl/alu_pkg.sv
// Shared constants, widths and FSM state type for the ALU scheduler slice.
// Opcode values are the command-word encoding seen on req_word*[11:8].
package alu_pkg;
    localparam int NREQ = 2;
    localparam int OPW  = 4;
    localparam int DW   = 4;

    localparam logic [OPW-1:0] OP_ADD  = 4'd0;
    localparam logic [OPW-1:0] OP_SUB  = 4'd1;
    localparam logic [OPW-1:0] OP_INC  = 4'd2;
    localparam logic [OPW-1:0] OP_DEC  = 4'd3;
    localparam logic [OPW-1:0] OP_COMP = 4'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;
endpackage

// File: rtl/alu_core.sv
// Combinational 4-bit execution core: result, carry/borrow, zero and illegal flags.
// Zero latency; no flow control.
module alu_core
    import alu_pkg::*;
(
    input  logic [OPW-1:0] i_op,
    input  logic [DW-1:0]  i_a,
    input  logic [DW-1:0]  i_b,
    output logic [DW-1:0]  o_result,
    output logic           o_carry,
    output logic           o_zero,
    output logic           o_illegal
);
    logic [DW:0] w_a5;
    logic [DW:0] w_b5;
    logic [DW:0] w_sum;

    assign w_a5 = {1'b0, i_a};
    assign w_b5 = {1'b0, i_b};

    // 5-bit wrap makes bit 4 the carry for ADD/INC and the borrow for SUB/DEC.
    always_comb begin
        w_sum     = '0;
        o_illegal = 1'b0;
        case (i_op)
            OP_ADD:  w_sum = w_a5 + w_b5;
            OP_SUB:  w_sum = w_a5 - w_b5;
            OP_INC:  w_sum = w_a5 + 5'd1;
            OP_DEC:  w_sum = w_a5 - 5'd1;
            OP_COMP: w_sum = {1'b0, ~i_a};
            default: o_illegal = 1'b1;
        endcase
    end

    assign o_result = w_sum[DW-1:0];
    assign o_carry  = w_sum[DW];
    assign o_zero   = (o_result == '0);
endmodule

// File: rtl/alu_scheduler.sv
// Round-robin two-requester scheduler around alu_core; one op in flight, response 2 cycles after accept.
// Backpressure: response held while rsp_ready low, no accepts until taken. Optional ALU_SCHED_CNT_EN adds grant counters.
module alu_scheduler
    import alu_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req_valid,
    input  logic [11:0]     req_word0,
    input  logic [11:0]     req_word1,
    output logic [NREQ-1:0] req_ready,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic            rsp_id,
    output logic [DW-1:0]   rsp_result,
    output logic            rsp_carry,
    output logic            rsp_zero,
    output logic            rsp_illegal
`ifdef ALU_SCHED_CNT_EN
    ,
    input  logic            cnt_clr,
    output logic [7:0]      grant_cnt0,
    output logic [7:0]      grant_cnt1
`endif
);
    state_t      r_state;
    logic        r_last_id;
    logic        r_id;
    logic [11:0] r_word;

    logic        w_gnt_id;
    logic        w_hs;
    logic [DW-1:0] w_result;
    logic        w_carry;
    logic        w_zero;
    logic        w_illegal;

    // With both valid, the requester that was not served last wins.
    assign w_gnt_id  = (req_valid == 2'b11) ? ~r_last_id : req_valid[1];
    assign w_hs      = (r_state == IDLE) && !rst && (req_valid != 2'b00);
    assign req_ready = w_hs ? (w_gnt_id ? 2'b10 : 2'b01) : 2'b00;

    alu_core u_core (
        .i_op      (r_word[11:8]),
        .i_a       (r_word[7:4]),
        .i_b       (r_word[3:0]),
        .o_result  (w_result),
        .o_carry   (w_carry),
        .o_zero    (w_zero),
        .o_illegal (w_illegal)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_last_id   <= 1'b1;
            r_id        <= 1'b0;
            r_word      <= '0;
            rsp_valid   <= 1'b0;
            rsp_id      <= 1'b0;
            rsp_result  <= '0;
            rsp_carry   <= 1'b0;
            rsp_zero    <= 1'b0;
            rsp_illegal <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (w_hs) begin
                    r_word    <= w_gnt_id ? req_word1 : req_word0;
                    r_id      <= w_gnt_id;
                    r_last_id <= w_gnt_id;
                    r_state   <= EXEC;
                end
                EXEC: begin
                    rsp_valid   <= 1'b1;
                    rsp_id      <= r_id;
                    rsp_result  <= w_result;
                    rsp_carry   <= w_carry;
                    rsp_zero    <= w_zero;
                    rsp_illegal <= w_illegal;
                    r_state     <= RESP;
                end
                RESP: if (rsp_ready) begin
                    rsp_valid <= 1'b0;
                    r_state   <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef ALU_SCHED_CNT_EN
    // Clear wins over a coincident grant.
    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
        end else if (w_hs) begin
            if (w_gnt_id) grant_cnt1 <= grant_cnt1 + 8'd1;
            else          grant_cnt0 <= grant_cnt0 + 8'd1;
        end
    end
`endif
endmodule

// File: tb/tb_alu_scheduler.sv
// Self-checking bench for alu_scheduler: directed steps plus randomized traffic against a behavioural model.
module tb_alu_scheduler;
    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [11:0] req_word0;
    logic [11:0] req_word1;
    logic [1:0]  req_ready;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [3:0]  rsp_result;
    logic        rsp_carry;
    logic        rsp_zero;
    logic        rsp_illegal;
`ifdef ALU_SCHED_CNT_EN
    logic        cnt_clr;
    logic [7:0]  grant_cnt0;
    logic [7:0]  grant_cnt1;
`endif

    int vectors = 0;
    int miscompares = 0;

    // Behavioural model state
    int          m_last;
    bit          m_busy;
    int          m_age;
    logic [11:0] m_word;
    int          m_id;

    always #5 clk = ~clk;

    alu_scheduler dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_word0   (req_word0),
        .req_word1   (req_word1),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_result  (rsp_result),
        .rsp_carry   (rsp_carry),
        .rsp_zero    (rsp_zero),
        .rsp_illegal (rsp_illegal)
`ifdef ALU_SCHED_CNT_EN
        ,
        .cnt_clr     (cnt_clr),
        .grant_cnt0  (grant_cnt0),
        .grant_cnt1  (grant_cnt1)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected {illegal, zero, carry, result[3:0]} straight from the opcode table.
    function automatic logic [6:0] model(input logic [11:0] w);
        int op, a, b, r, c, ill;
        op = w[11:8]; a = w[7:4]; b = w[3:0]; c = 0; ill = 0;
        case (op)
            0: begin r = a + b;  c = (r > 15) ? 1 : 0; end
            1: begin r = a - b;  c = (a < b) ? 1 : 0; end
            2: begin r = a + 1;  c = (a == 15) ? 1 : 0; end
            3: begin r = a - 1;  c = (a == 0) ? 1 : 0; end
            4: begin r = 15 - a; c = 0; end
            default: begin r = 0; ill = 1; end
        endcase
        r = r & 15;
        return {ill[0], (r == 0), c[0], r[3:0]};
    endfunction

    function automatic int winner(input logic [1:0] v, input int last);
        if (v == 2'b11) return 1 - last;
        return v[1] ? 1 : 0;
    endfunction

    task automatic check_rsp(input string tag, input int id, input logic [11:0] w);
        check({tag, "_vld"}, rsp_valid, 1);
        check({tag, "_id"}, rsp_id, id);
        check({tag, "_pay"}, {rsp_illegal, rsp_zero, rsp_carry, rsp_result}, model(w));
    endtask

    // Single-requester op; entered and left at posedge+1 with the DUT idle.
    task automatic do_op(input string tag, input int r, input logic [11:0] w);
        int n;
        rsp_ready = 1'b1;
        req_valid = (r == 1) ? 2'b10 : 2'b01;
        if (r == 1) req_word1 = w; else req_word0 = w;
        #1;
        n = 0;
        while (req_ready == 2'b00 && n < 20) begin
            @(posedge clk); #1; n++;
        end
        check({tag, "_rdy"}, req_ready, (r == 1) ? 2'b10 : 2'b01);
        @(posedge clk);
        m_last = r;
        #1;
        req_valid = 2'b00;
        check({tag, "_exec"}, rsp_valid, 0);
        @(posedge clk); #1;
        check_rsp(tag, r, w);
        @(posedge clk); #1;
        check({tag, "_done"}, rsp_valid, 0);
    endtask

    // vmode: 0 random valids, 1 both valid, 2 none. rmode: 0 random rsp_ready, 1 always ready.
    task automatic run_rand(input int cycles, input int vmode, input int rmode);
        logic [1:0] exp_rdy;
        bit exp_v, hs, taken;
        int g;
        logic [11:0] w;
        for (int i = 0; i < cycles; i++) begin
            req_valid = (vmode == 1) ? 2'b11 : (vmode == 2) ? 2'b00 : 2'($urandom);
            req_word0 = 12'($urandom);
            req_word1 = 12'($urandom);
            rsp_ready = (rmode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
            #1;
            g = winner(req_valid, m_last);
            exp_rdy = (!m_busy && req_valid != 2'b00) ? ((g == 1) ? 2'b10 : 2'b01) : 2'b00;
            exp_v = m_busy && m_age >= 1;
            check("rand_rdy", req_ready, exp_rdy);
            check("rand_vld", rsp_valid, exp_v);
            if (exp_v) begin
                check("rand_id", rsp_id, m_id);
                check("rand_pay", {rsp_illegal, rsp_zero, rsp_carry, rsp_result}, model(m_word));
            end
            hs = (exp_rdy != 2'b00);
            w = (g == 1) ? req_word1 : req_word0;
            taken = exp_v && rsp_ready;
            @(posedge clk);
            if (taken) m_busy = 0;
            else if (m_busy) m_age++;
            if (hs) begin
                m_busy = 1; m_age = 0; m_word = w; m_id = g; m_last = g;
            end
            #1;
        end
    endtask

    initial begin
        logic [6:0] held;
        rst = 1'b1;
        req_valid = 2'b11;
        req_word0 = 12'h035;
        req_word1 = 12'h135;
        rsp_ready = 1'b1;
`ifdef ALU_SCHED_CNT_EN
        cnt_clr = 1'b0;
`endif
        m_last = 1; m_busy = 0; m_age = 0; m_word = '0; m_id = 0;

        // Reset state
        @(posedge clk); #1;
        check("rst_rdy", req_ready, 2'b00);
        check("rst_out", {rsp_valid, rsp_id, rsp_illegal, rsp_zero, rsp_carry, rsp_result}, 0);
        @(posedge clk); #1;
        req_valid = 2'b00;
        rst = 1'b0;

        // Directed operations
        do_op("add", 0, 12'h035);
        do_op("sub", 1, 12'h135);
        do_op("inc", 1, 12'h2F0);
        do_op("ill", 0, 12'h9AB);
        do_op("comp", 0, 12'h450);
        do_op("dec0", 1, 12'h300);

        // Both requesters continuously valid with rsp_ready high: strict alternation
        run_rand(30, 1, 1);
        run_rand(4, 2, 1);

        // Backpressure: response held 5 cycles with req0 waiting
        rsp_ready = 1'b1;
        req_valid = 2'b10;
        req_word1 = 12'h0F1;
        @(posedge clk); #1;
        m_last = 1;
        req_valid = 2'b01;
        req_word0 = 12'h1A3;
        rsp_ready = 1'b0;
        @(posedge clk); #1;
        held = model(12'h0F1);
        for (int i = 0; i < 5; i++) begin
            check("bp_vld", rsp_valid, 1);
            check("bp_pay", {rsp_id, rsp_illegal, rsp_zero, rsp_carry, rsp_result}, {1'b1, held});
            check("bp_rdy", req_ready, 2'b00);
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        #1;
        check("bp_last_rdy", req_ready, 2'b00);
        @(posedge clk); #1;
        check("bp_accept", req_ready, 2'b01);
        @(posedge clk); #1;
        m_last = 0;
        req_valid = 2'b00;
        @(posedge clk); #1;
        check_rsp("bp_next", 0, 12'h1A3);
        @(posedge clk); #1;

        // Reset while the command is executing
        req_valid = 2'b10;
        req_word1 = 12'h077;
        @(posedge clk); #1;
        req_valid = 2'b00;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        m_last = 1;
        for (int i = 0; i < 3; i++) begin
            check("rstx_out", {rsp_valid, rsp_id, rsp_illegal, rsp_zero, rsp_carry, rsp_result}, 0);
            @(posedge clk); #1;
        end

        // Randomized traffic with random backpressure
        run_rand(400, 0, 0);
        run_rand(4, 2, 1);

`ifdef ALU_SCHED_CNT_EN
        cnt_clr = 1'b1;
        @(posedge clk); #1;
        cnt_clr = 1'b0;
        for (int i = 0; i < 256; i++) do_op("cnt", 0, 12'($urandom));
        check("cnt0_wrap", grant_cnt0, 0);
        do_op("cnt1", 1, 12'h011);
        check("cnt1_one", grant_cnt1, 1);
        cnt_clr = 1'b1;
        @(posedge clk); #1;
        cnt_clr = 1'b0;
        check("cnt_clr", {grant_cnt0, grant_cnt1}, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
